// File: rtl/mem_resp_pkg.sv
// Shared constants and state encoding for the RV32 memory responder.
// Holds the MMIO addresses, the NOP encoding returned on illegal fetches,
// and the boot-loader FSM state enum.
package mem_resp_pkg;

  localparam logic [31:0] MMIO_TX_ADDR     = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_STATUS_ADDR = 32'hFFFF_FFF4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered pointers; head is read straight out of storage.
// Latency: a push at edge N is visible on o_head / !o_empty from cycle N+1.
// Backpressure: push is accepted when not full, or when full and a pop happens the same cycle.
// Ports: clk, reset (sync, active-high), i_flush (empties the FIFO), i_push/i_dat,
//        i_pop, o_full, o_empty, o_head (entry at the read pointer).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot this same cycle, so a push to a full FIFO still fits.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !reset) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/memory_responder.sv
// Unified instruction/data word RAM for a single-cycle RV32 core, with a byte-stream
// boot loader (core held in reset while loading) and a write-only MMIO TX port.
// Latency: reads combinational, writes land at the clock edge; TX data visible the cycle after push.
// Backpressure: load_ready only in LOAD; TX pushes to a full FIFO are dropped and flag err.
// Ports: clk/reset (sync, active-high); pc->instruction fetch; we/address/wdata->rdata data port;
//        load_start/load_valid/load_ready/load_byte/load_last boot stream; cpu_reset to the core;
//        tx_valid/tx_ready/tx_data MMIO output; err sticky access error.
// Build option MEMRESP_MMIO_EN: when defined, the TX FIFO and status register exist; when
// undefined, the MMIO addresses behave as out-of-range and the TX port is tied off.
module memory_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        cpu_reset,
  input  logic        load_start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_t        r_state;
  logic          r_cpu_reset;
  logic          r_load_ready;
  logic          r_err;
  logic [1:0]    r_byte_cnt;
  logic [AW-1:0] r_wptr;
  logic [31:0]   r_asm;

  logic          w_run;
  logic          w_pc_legal;
  logic          w_d_legal;
  logic          w_load_acc;
  logic          w_word_wr;
  logic [31:0]   w_asm_word;
  logic          w_wrap;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_idx;
  logic [31:0]   w_ram_wdat;
  logic          w_mmio_hit;
  logic          w_push_drop;
  logic [31:0]   w_mmio_rdata;
  logic          w_cpu_err;

  assign w_run      = (r_state == RUN);
  assign w_pc_legal = (pc[31:AW+2] == '0) && (pc[1:0] == 2'b00);
  assign w_d_legal  = (address[31:AW+2] == '0) && (address[1:0] == 2'b00);

  // Loader: new byte merged into its lane; upper lanes stay zero because r_asm is
  // cleared after every word write, which is what a short final word needs.
  assign w_load_acc = (r_state == LOAD) && r_load_ready && load_valid;
  assign w_word_wr  = w_load_acc && ((r_byte_cnt == 2'd3) || load_last);
  assign w_asm_word = r_asm | ({24'b0, load_byte} << {r_byte_cnt, 3'b000});
  assign w_wrap     = w_word_wr && (r_wptr == AW'(DEPTH_WORDS - 1));

  // Single RAM write port: loader owns it in LOAD, the core in RUN.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_idx  = address[AW+1:2];
    w_ram_wdat = wdata;
    if (r_state == LOAD) begin
      w_ram_we   = w_word_wr;
      w_ram_idx  = r_wptr;
      w_ram_wdat = w_asm_word;
    end else if (w_run) begin
      w_ram_we   = we && w_d_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we && !reset) r_mem[w_ram_idx] <= w_ram_wdat;
  end

`ifdef MEMRESP_MMIO_EN
  logic        w_tx_hit;
  logic        w_st_hit;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;

  assign w_tx_hit    = (address == MMIO_TX_ADDR);
  assign w_st_hit    = (address == MMIO_STATUS_ADDR);
  assign w_mmio_hit  = w_tx_hit || w_st_hit;
  assign w_push      = w_run && we && w_tx_hit;
  assign w_pop       = !w_empty && tx_ready;
  assign w_push_drop = w_push && w_full && !w_pop;
  assign w_flush     = w_run && load_start;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_dat   (wdata),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign tx_valid     = !w_empty;
  // Storage is not reset, so mask the head while nothing is queued.
  assign tx_data      = w_empty ? 32'h0 : w_head;
  assign w_mmio_rdata = w_st_hit ? {30'b0, w_full, w_empty} : 32'h0;
`else
  logic w_unused_tx;

  assign w_mmio_hit   = 1'b0;
  assign w_push_drop  = 1'b0;
  assign w_mmio_rdata = 32'h0;
  assign tx_valid     = 1'b0;
  assign tx_data      = 32'h0;
  assign w_unused_tx  = tx_ready;
`endif

  assign instruction = w_pc_legal ? r_mem[pc[AW+1:2]] : NOP_INSTR;
  assign rdata       = w_d_legal ? r_mem[address[AW+1:2]] : w_mmio_rdata;

  // The core has no read strobe, so whatever it drives on address counts as an access.
  assign w_cpu_err = !r_cpu_reset &&
                     (!w_pc_legal || (!w_d_legal && !w_mmio_hit) || w_push_drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_cpu_reset  <= 1'b0;
      r_load_ready <= 1'b0;
      r_byte_cnt   <= 2'd0;
      r_wptr       <= '0;
      r_asm        <= 32'h0;
    end else begin
      case (r_state)
        RUN: begin
          if (load_start) begin
            r_state      <= LOAD;
            r_cpu_reset  <= 1'b1;
            r_load_ready <= 1'b1;
            r_byte_cnt   <= 2'd0;
            r_wptr       <= '0;
            r_asm        <= 32'h0;
          end
        end
        LOAD: begin
          if (w_load_acc) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_word_wr) begin
              r_asm  <= 32'h0;
              r_wptr <= r_wptr + AW'(1);
            end else begin
              r_asm  <= w_asm_word;
            end
            if (load_last) begin
              r_state      <= RELEASE;
              r_load_ready <= 1'b0;
            end
          end
        end
        RELEASE: begin
          r_state     <= RUN;
          r_cpu_reset <= 1'b0;
        end
        default: begin
          r_state      <= RUN;
          r_cpu_reset  <= 1'b0;
          r_load_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else if (w_cpu_err || w_wrap) r_err <= 1'b1;
  end

  assign cpu_reset  = r_cpu_reset;
  assign load_ready = r_load_ready;
  assign err        = r_err;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: stimulus queues expected values, a negedge monitor
// pops and compares them, and a separate TX monitor checks each tx handshake in order.
// Latency/backpressure: exercises combinational reads, edge writes, boot load and TX drain.
module tb_memory_responder;

  localparam int DEPTH_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        we;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        cpu_reset;
  logic        load_start;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        err;

  int total = 0;
  int bad   = 0;

  string       name_q[$];
  int          sel_q[$];
  logic [31:0] val_q[$];
  logic [31:0] tx_q[$];

  memory_responder #(.DEPTH_WORDS(DEPTH_WORDS), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .we(we), .address(address), .wdata(wdata), .rdata(rdata),
    .cpu_reset(cpu_reset), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_byte(load_byte), .load_last(load_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .err(err)
  );

  always #5 clk = ~clk;

  localparam int S_INSTR = 0, S_RDATA = 1, S_CPURST = 2, S_LRDY = 3,
                 S_ERR = 4, S_TXV = 5, S_TXD = 6;

  function automatic logic [31:0] pick(input int s);
    case (s)
      S_INSTR:  return instruction;
      S_RDATA:  return rdata;
      S_CPURST: return {31'b0, cpu_reset};
      S_LRDY:   return {31'b0, load_ready};
      S_ERR:    return {31'b0, err};
      S_TXV:    return {31'b0, tx_valid};
      default:  return tx_data;
    endcase
  endfunction

  // Scoreboard monitor: compare queued expectations and TX handshakes mid-cycle.
  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      string       nm;
      int          s;
      logic [31:0] e;
      logic [31:0] a;
      nm = name_q.pop_front();
      s  = sel_q.pop_front();
      e  = val_q.pop_front();
      a  = pick(s);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %08h expected %08h", nm, a, e);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      total++;
      if (tx_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got %08h expected no transfer", tx_data);
      end else begin
        logic [31:0] e;
        e = tx_q.pop_front();
        if (tx_data !== e) begin
          bad++;
          $display("FAIL tx_data: got %08h expected %08h", tx_data, e);
        end
      end
    end
  end

  task automatic chk(input int s, input logic [31:0] v, input string nm);
    name_q.push_back(nm);
    sel_q.push_back(s);
    val_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    address = a;
    chk(S_RDATA, v, nm);
    tick();
  endtask

  logic [7:0] img1 [8];
  logic [7:0] img2 [6];

  initial begin
    img1 = '{8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'hb0, 8'h00};
    img2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    reset = 1'b1; pc = 32'h0; we = 1'b0; address = 32'h0; wdata = 32'h0;
    load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
    tx_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk(S_CPURST, 0, "rst_cpu_reset");
    chk(S_LRDY,   0, "rst_load_ready");
    chk(S_TXV,    0, "rst_tx_valid");
    chk(S_TXD,    0, "rst_tx_data");
    chk(S_ERR,    0, "rst_err");
    tick();

    // Boot load of two full words.
    start_load();
    chk(S_CPURST, 1, "load1_cpu_reset_high");
    chk(S_LRDY,   1, "load1_ready_high");
    for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
    chk(S_CPURST, 1, "release_cpu_reset_high");
    chk(S_LRDY,   0, "release_ready_low");
    tick();
    chk(S_CPURST, 0, "run_cpu_reset_low");
    rd(32'h0, 32'h00a00513, "load1_word0");
    rd(32'h4, 32'h00b00593, "load1_word1");
    pc = 32'h4;
    chk(S_INSTR, 32'h00b00593, "load1_fetch1");
    chk(S_ERR, 0, "load1_no_err");
    tick();
    pc = 32'h0;

    // Short final word, then an aborted load.
    start_load();
    for (int i = 0; i < 6; i++) send_byte(img2[i], i == 5);
    tick();
    rd(32'h0, 32'h04030201, "load2_word0");
    rd(32'h4, 32'h00000605, "load2_partial_word1");
    start_load();
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    do_reset();
    chk(S_CPURST, 0, "abort_cpu_reset_low");
    chk(S_LRDY,   0, "abort_ready_low");
    rd(32'h0, 32'h04030201, "abort_word0_kept");

    // Write-then-read timing.
    we = 1'b1; address = 32'h10; wdata = 32'h11112222;
    tick();
    wdata = 32'hDEADBEEF;
    chk(S_RDATA, 32'h11112222, "same_cycle_old_value");
    tick();
    we = 1'b0; pc = 32'h10;
    chk(S_RDATA, 32'hDEADBEEF, "next_cycle_new_value");
    chk(S_INSTR, 32'hDEADBEEF, "fetch_new_value");
    chk(S_ERR, 0, "legal_write_no_err");
    tick();
    pc = 32'h0;

    // Misaligned data write is dropped and flagged.
    we = 1'b1; address = 32'h11; wdata = 32'h00000055;
    chk(S_RDATA, 0, "misaligned_read_zero");
    tick();
    we = 1'b0; address = 32'h10;
    chk(S_ERR, 1, "misaligned_err");
    chk(S_RDATA, 32'hDEADBEEF, "misaligned_write_dropped");
    tick();
    rd(32'h400, 32'h0, "oob_read_zero");
    address = 32'h0;
    do_reset();
    chk(S_ERR, 0, "err_cleared_by_reset");
    tick();

    // Last legal word, then illegal fetch.
    we = 1'b1; address = 32'h3FC; wdata = 32'hCAFEF00D;
    tick();
    we = 1'b0; pc = 32'h3FC;
    chk(S_RDATA, 32'hCAFEF00D, "top_word_read");
    chk(S_INSTR, 32'hCAFEF00D, "top_word_fetch");
    tick();
    address = 32'h0;
    chk(S_ERR, 0, "top_word_no_err");
    pc = 32'h400;
    chk(S_INSTR, 32'h00000013, "oob_pc_nop");
    tick();
    pc = 32'h6;
    chk(S_INSTR, 32'h00000013, "misaligned_pc_nop");
    chk(S_ERR, 1, "oob_pc_err");
    tick();
    pc = 32'h0;
    do_reset();

`ifdef MEMRESP_MMIO_EN
    rd(32'hFFFF_FFF4, 32'h1, "status_empty");
    for (int i = 1; i <= 4; i++) begin
      we = 1'b1; address = 32'hFFFF_FFF0; wdata = 32'(i);
      tx_q.push_back(32'(i));
      tick();
    end
    we = 1'b0; address = 32'hFFFF_FFF4;
    chk(S_RDATA, 32'h2, "status_full");
    chk(S_TXV, 1, "tx_valid_after_push");
    chk(S_TXD, 1, "tx_head_first");
    chk(S_ERR, 0, "no_err_before_overflow");
    tick();
    rd(32'hFFFF_FFF0, 32'h0, "tx_addr_reads_zero");
    we = 1'b1; address = 32'hFFFF_FFF0; wdata = 32'h5;
    tick();
    we = 1'b0; address = 32'h0;
    chk(S_ERR, 1, "overflow_err");
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_valid == 1'b0) break;
    end
    total++;
    if (tx_q.size() != 0) begin
      bad++;
      $display("FAIL tx_drain: remaining %0d expected 0", tx_q.size());
    end
    tx_ready = 1'b0;
    rd(32'hFFFF_FFF4, 32'h1, "status_empty_after_drain");
`else
    tx_ready = 1'b1;
    we = 1'b1; address = 32'hFFFF_FFF0; wdata = 32'h5;
    chk(S_RDATA, 0, "nommio_read_zero");
    tick();
    we = 1'b0; address = 32'h0;
    chk(S_ERR, 1, "nommio_err");
    chk(S_TXV, 0, "nommio_tx_valid");
    chk(S_TXD, 0, "nommio_tx_data");
    tick();
    tx_ready = 1'b0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
